branch_resolve_unit: RTL
========================

// Module: branch_resolve_unit
// PURPOSE
//  Carries per-instruction branch-prediction metadata from IF through IF/ID and ID/EX.
//  Resolves conditional branches in EX against the ALU outcome.
//  On a wrong prediction it raises mispredict, supplies the recovery PC and flushes IF/ID and ID/EX.
//  Returns the trained outcome (op, taken) to the 2-bit predictor and keeps saturating branch/mispredict counters.
// PARAMETERS
//  XLEN       32        datapath / PC width
//  CNT_W      32        width of statistics counters
//  BR_OPCODE  5'b11000  inst[6:2] value identifying a conditional branch
// PORTS
//  clk            in   1      clock
//  rst            in   1      asynchronous, active-high reset
//  f_valid        in   1      fetch slot holds a real instruction
//  f_pc           in   XLEN   PC of fetched instruction
//  f_inst         in   32     fetched instruction word
//  f_predict      in   1      predictor direction for f_inst (1 = taken)
//  stall          in   1      load-use stall: hold IF/ID, bubble into ID/EX
//  e_b_take       in   1      ALU branch condition result for the EX instruction
//  e_op           out  5      opcode[6:2] of valid EX instruction, else 5'b0 (predictor training op)
//  e_taken        out  1      = e_b_take when EX holds a valid branch, else 0
//  mispredict     out  1      EX branch direction != stored prediction
//  redirect_pc    out  XLEN   recovery PC; valid only when mispredict = 1
//  flush_if_id    out  1      invalidate IF/ID slot (= mispredict)
//  flush_id_ex    out  1      invalidate ID/EX slot (= mispredict)
//  br_count       out  CNT_W  resolved branches, saturating
//  mis_count      out  CNT_W  mispredicted branches, saturating
// BEHAVIOUR
//  Slot contents
//   - Each slot holds {valid, is_br, pred, op[4:0], pc, tgt}.
//   - is_br = (inst[6:2] == BR_OPCODE).
//   - tgt = pc + sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), modulo 2^XLEN.
//  Reset
//   - Both slots invalid; all other slot fields 0.
//   - Counters 0; all outputs 0.
//   - Reset mid-operation discards in-flight metadata immediately.
//  Per-cycle update, priority high to low:
//   1. Mispredict: IF/ID.valid <= 0 and ID/EX.valid <= 0, regardless of stall.
//   2. Stall: IF/ID holds; ID/EX.valid <= 0 (bubble).
//   3. Otherwise: IF/ID <= fetch capture (valid = f_valid); ID/EX <= IF/ID.
//  Resolve
//   - Combinational, 0-cycle latency from e_b_take; active when ID/EX.valid && ID/EX.is_br.
//   - mispredict = e_b_take ^ ID/EX.pred.
//   - redirect_pc = e_b_take ? ID/EX.tgt : ID/EX.pc + 4.
//   - Non-branch or invalid EX slot: mispredict = 0, redirect_pc = 0.
//  Training
//   - e_op/e_taken are driven every cycle from the ID/EX slot.
//   - The predictor updates its state on the next clk edge.
//   - A flushed (invalid) slot never trains.
//  Counters
//   - br_count += 1 on each resolve cycle.
//   - mis_count += 1 when mispredict is also set.
//   - Both hold at {CNT_W{1'b1}} and do not wrap.
//  Boundaries
//   - Back-to-back branches: a wrong-path branch sitting in IF/ID during a mispredict is flushed and never resolved or counted.
//   - stall with a valid EX branch: the branch still resolves this cycle; the bubble follows it.
//   - PC+4 and tgt wrap modulo 2^XLEN.
// STRUCTURE
//  - Shared header pipe_defs.vh: BR_OPCODE, XLEN, slot field widths/offsets.
//  - Sub-module br_meta_slot: one pipeline register slot with async reset, load/hold/clear controls.
//    Instantiated twice (IF/ID, ID/EX).
//  - Immediate decode, resolve compare and counters stay in the top module.
// TESTING
//  1. Reset: assert rst mid-stream with valid slots -> mispredict = 0, counters 0, e_op = 0, no resolve next 2 cycles.
//  2. Correct taken prediction:
//     - Stimulus: f_pc = 0x100, beq imm = +16, f_predict = 1, then e_b_take = 1 two cycles later.
//     - Response: mispredict = 0, br_count = 1, e_op = 5'b11000, e_taken = 1.
//  3. Predicted taken, actually not taken:
//     - Stimulus: same branch, e_b_take = 0.
//     - Response: mispredict = 1, redirect_pc = 0x104, flush_if_id = flush_id_ex = 1, mis_count = 1.
//  4. Predicted not taken, actually taken:
//     - Stimulus: f_pc = 0x200, imm = -8.
//     - Response: redirect_pc = 0x1F8, following wrong-path branch never counted.
//  5. Stall with branch in IF/ID for 2 cycles -> branch resolves exactly once, 2 bubbles seen (e_op = 0).
//  6. Saturation: preload counters near max (CNT_W = 4), 20 mispredicts -> both stick at 4'hF.

Source files
------------

// File: rtl/branch_resolve_unit_pkg.sv
// ============================================================================
//  branch_resolve_unit_pkg : shared widths, opcode and B-type immediate decode
//  Revision 1.0
// ============================================================================
`default_nettype none

package branch_resolve_unit_pkg;

  localparam int unsigned DEF_XLEN      = 32;
  localparam int unsigned DEF_CNT_W     = 32;
  localparam logic [4:0]  DEF_BR_OPCODE = 5'b11000;
  localparam int unsigned OP_W          = 5;
  localparam int unsigned IMM_W         = 13;

  // B-type offset, bit 0 implicitly zero
  function automatic logic [IMM_W-1:0] b_imm(input logic [31:0] inst);
    return {inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

endpackage

`default_nettype wire

// File: rtl/br_meta_slot.sv
// ============================================================================
//  br_meta_slot : one branch-metadata pipeline slot, clear > load > hold
//  Revision 1.0
// ============================================================================
`default_nettype none

module br_meta_slot
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic            i_clear,
  input  logic            i_valid,
  input  logic            i_is_br,
  input  logic            i_pred,
  input  logic [OP_W-1:0] i_op,
  input  logic [XLEN-1:0] i_pc,
  input  logic [XLEN-1:0] i_tgt,
  output logic            o_valid,
  output logic            o_is_br,
  output logic            o_pred,
  output logic [OP_W-1:0] o_op,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_tgt
);

  logic            r_valid;
  logic            r_is_br;
  logic            r_pred;
  logic [OP_W-1:0] r_op;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_tgt;

  // Clearing only drops valid; stale payload is harmless behind it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_is_br <= 1'b0;
      r_pred  <= 1'b0;
      r_op    <= '0;
      r_pc    <= '0;
      r_tgt   <= '0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= i_valid;
      r_is_br <= i_is_br;
      r_pred  <= i_pred;
      r_op    <= i_op;
      r_pc    <= i_pc;
      r_tgt   <= i_tgt;
    end
  end

  assign o_valid = r_valid;
  assign o_is_br = r_is_br;
  assign o_pred  = r_pred;
  assign o_op    = r_op;
  assign o_pc    = r_pc;
  assign o_tgt   = r_tgt;

endmodule

`default_nettype wire

// File: rtl/branch_resolve_unit.sv
// ============================================================================
//  branch_resolve_unit : carries prediction metadata IF->EX, resolves branches,
//  drives recovery/flush, predictor training and saturating statistics.
//  Revision 1.0
// ============================================================================
`default_nettype none

module branch_resolve_unit
  import branch_resolve_unit_pkg::*;
#(
  parameter int unsigned XLEN      = DEF_XLEN,
  parameter int unsigned CNT_W     = DEF_CNT_W,
  parameter logic [4:0]  BR_OPCODE = DEF_BR_OPCODE
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             f_valid,
  input  logic [XLEN-1:0]  f_pc,
  input  logic [31:0]      f_inst,
  input  logic             f_predict,
  input  logic             stall,
  input  logic             e_b_take,
  output logic [4:0]       e_op,
  output logic             e_taken,
  output logic             mispredict,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int unsigned     c_EXT_W   = XLEN - IMM_W;
  localparam logic [XLEN-1:0] c_PC_STEP = XLEN'(4);
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  logic [IMM_W-1:0] w_imm;
  logic             w_f_is_br;
  logic [XLEN-1:0]  w_f_tgt;

  logic             w_id_valid, w_id_is_br, w_id_pred;
  logic [OP_W-1:0]  w_id_op;
  logic [XLEN-1:0]  w_id_pc, w_id_tgt;

  logic             w_ex_valid, w_ex_is_br, w_ex_pred;
  logic [OP_W-1:0]  w_ex_op;
  logic [XLEN-1:0]  w_ex_pc, w_ex_tgt;

  logic             w_resolve;
  logic             w_mispredict;
  logic [CNT_W-1:0] r_br_count;
  logic [CNT_W-1:0] r_mis_count;

  assign w_imm     = b_imm(f_inst);
  assign w_f_is_br = (f_inst[6:2] == BR_OPCODE);
  assign w_f_tgt   = f_pc + {{c_EXT_W{w_imm[IMM_W-1]}}, w_imm};

  br_meta_slot #(.XLEN(XLEN)) u_if_id (
    .clk     (clk),
    .rst     (rst),
    .i_load  (!stall),
    .i_clear (w_mispredict),
    .i_valid (f_valid),
    .i_is_br (w_f_is_br),
    .i_pred  (f_predict),
    .i_op    (f_inst[6:2]),
    .i_pc    (f_pc),
    .i_tgt   (w_f_tgt),
    .o_valid (w_id_valid),
    .o_is_br (w_id_is_br),
    .o_pred  (w_id_pred),
    .o_op    (w_id_op),
    .o_pc    (w_id_pc),
    .o_tgt   (w_id_tgt)
  );

  // A stall holds IF/ID, so ID/EX takes a bubble instead of a copy
  br_meta_slot #(.XLEN(XLEN)) u_id_ex (
    .clk     (clk),
    .rst     (rst),
    .i_load  (1'b1),
    .i_clear (w_mispredict | stall),
    .i_valid (w_id_valid),
    .i_is_br (w_id_is_br),
    .i_pred  (w_id_pred),
    .i_op    (w_id_op),
    .i_pc    (w_id_pc),
    .i_tgt   (w_id_tgt),
    .o_valid (w_ex_valid),
    .o_is_br (w_ex_is_br),
    .o_pred  (w_ex_pred),
    .o_op    (w_ex_op),
    .o_pc    (w_ex_pc),
    .o_tgt   (w_ex_tgt)
  );

  assign w_resolve    = w_ex_valid & w_ex_is_br;
  assign w_mispredict = w_resolve & (e_b_take ^ w_ex_pred);

  assign mispredict  = w_mispredict;
  assign flush_if_id = w_mispredict;
  assign flush_id_ex = w_mispredict;
  assign redirect_pc = !w_resolve ? '0 :
                       e_b_take   ? w_ex_tgt : (w_ex_pc + c_PC_STEP);
  assign e_op        = w_ex_valid ? w_ex_op : '0;
  assign e_taken     = w_resolve & e_b_take;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_br_count  <= '0;
      r_mis_count <= '0;
    end else begin
      if (w_resolve && (r_br_count != c_CNT_MAX))
        r_br_count <= r_br_count + 1'b1;
      if (w_mispredict && (r_mis_count != c_CNT_MAX))
        r_mis_count <= r_mis_count + 1'b1;
    end
  end

  assign br_count  = r_br_count;
  assign mis_count = r_mis_count;

endmodule

`default_nettype wire
